main_memory_arbiter: RTL and testbench
======================================

// Module: main_memory_arbiter
// PURPOSE
// - Shares one port of the dual-port main memory (18-bit address, 24-bit word) between NUM_REQ requesters.
// - Requesters are processing lanes or the DMA loader.
// - Round-robin grant, at most one memory access per cycle.
// - Read data is routed back to its requester with a tagged valid.
// - pause/drain FSM quiesces the port for external access (e.g. host load over port B).
// PARAMETERS
// NUM_REQ     4   number of requesters (2..8)
// ADDR_W      18  memory address width
// DATA_W      24  memory word width
// MEM_RD_LAT  1   cycles from grant edge to valid mem_q (1..3)
// CNT_W       16  width of each grant counter (ARB_STATS_EN only)
// PORTS
// clk          in   1               system clock; memory samples on the same edge as arbiter state
// rst          in   1               asynchronous, active-high reset
// pause        in   1               request to stop issuing grants
// paused       out  1               port quiescent: no grants, no reads in flight
// req          in   NUM_REQ         per-requester access request, held until granted
// we           in   NUM_REQ         1 = write, 0 = read, per requester
// addr         in   NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
// wdata        in   NUM_REQ*DATA_W  packed write data
// gnt          out  NUM_REQ         one-hot (or zero) grant, combinational, same cycle as req
// rvalid       out  NUM_REQ         one-hot read-data-valid
// rdata        out  DATA_W          read data, broadcast; qualified by rvalid
// mem_address  out  ADDR_W          to memory address port
// mem_data     out  DATA_W          to memory data port
// mem_wren     out  1               to memory write enable
// mem_q        in   DATA_W          from memory q port
// grant_count  out  NUM_REQ*CNT_W   per-requester grant counters (ARB_STATS_EN only)
// BEHAVIOUR
// - Reset values:
//   - gnt=0, rvalid=0, rdata=0, mem_wren=0, mem_address=0, mem_data=0, paused=0.
//   - rr_ptr=0; FSM=RUN; read tag pipe cleared.
// - Arbitration, state RUN only:
//   - Search req starting at rr_ptr, wrapping at NUM_REQ-1 -> 0; first set bit i wins; gnt[i]=1.
//   - On the clock edge with gnt[i]=1: rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
// - Memory drive:
//   - mem_address/mem_data/mem_wren come combinationally from the winner.
//   - mem_wren = we[i] & gnt[i].
//   - With no grant: mem_wren=0, address and data hold their last value (registered mux select).
// - Read return:
//   - A granted read pushes tag {valid, i} into a MEM_RD_LAT-deep shift pipe.
//   - At pipe output: rvalid[i]=1, rdata=mem_q, exactly MEM_RD_LAT cycles after the grant edge.
//   - Back-to-back reads from any mix of requesters return in grant order, one per cycle.
//   - A granted write produces no rvalid.
//   - Same-address write then read in the next cycle returns the new data (memory write-first).
// - Requester contract: after gnt it may change req/addr next cycle. Dropping req before gnt is legal (request withdrawn).
// - FSM:
//   - RUN --pause--> DRAIN. Pause is sampled on the edge; a grant already issued in the same cycle completes.
//   - DRAIN: gnt=0. When the tag pipe is empty -> PAUSED.
//   - PAUSED: paused=1, gnt=0. When pause=0 -> RUN, with paused=0 on the next cycle.
//   - DRAIN with pause=0 -> RUN immediately; remaining reads still return.
// - Boundary conditions:
//   - All req=0 in RUN: idle, no memory write.
//   - All req=1: strict rotation 0,1,2,3,0...
//   - Reset mid-operation: in-flight tags discarded and no rvalid for them; memory contents untouched.
// CONFIGURATION
// - ARB_STATS_EN defined:
//   - grant_count[i] increments on every grant edge to i.
//   - Saturates at 2^CNT_W-1; cleared by rst only.
// - ARB_STATS_EN undefined: grant_count port and counters absent; all other behaviour identical.
// TESTING
// 1. Reset, then req=4'b0001, we=0, addr0=0 -> gnt=0001 same cycle; rvalid[0]=1, rdata=24'hFFFFFF (init image) MEM_RD_LAT cycles later.
// 2. Req0 write addr=10 data=65535, next cycle req1 read addr=10 -> rvalid[1]=1, rdata=65535; rvalid[0] never set.
// 3. req=4'b1111 held 8 cycles, all reads, distinct addrs -> gnt order 0,1,2,3,0,1,2,3; rvalid in the same order, one per cycle.
// 4. Req2 granted (rr_ptr=3), then req=4'b0101 -> gnt order 0 then 2 (wrap from ptr 3).
// 5. Read to addr 200000 in flight, pause=1 -> gnt=0; read returns 3444 (previously written); paused=1 after drain; pause=0 -> grants resume next cycle.
// 6. Assert rst with two reads in flight -> no rvalid afterwards, rr_ptr=0; with ARB_STATS_EN, grant_count=0 after rst and =5 after 5 grants to req3.

Source files
------------

// File: rtl/main_memory_arbiter.sv
// Purpose : round-robin arbiter sharing one main-memory port between NUM_REQ requesters,
//           routing read data back with a tagged valid and a pause/drain FSM for host access.
// Latency : grant is combinational with req; read data returns MEM_RD_LAT cycles after the grant edge.
// Backpressure: a requester holds req until gnt; pause stops new grants and drains reads in flight.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   pause / paused        quiesce request / port quiescent indication
//   req, we, addr, wdata  per-requester request, write enable, packed address and write data
//   gnt, rvalid, rdata    one-hot grant, one-hot read valid, broadcast read data
//   mem_address, mem_data, mem_wren, mem_q   memory port
//   grant_count           per-requester saturating grant counters (only with ARB_STATS_EN)
// Optional feature macro: ARB_STATS_EN
module main_memory_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 24,
  parameter int MEM_RD_LAT = 1,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pause,
  output logic                        paused,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          we,
  input  logic [NUM_REQ*ADDR_W-1:0]   addr,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          rvalid,
  output logic [DATA_W-1:0]           rdata,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [DATA_W-1:0]           mem_data,
  output logic                        mem_wren,
  input  logic [DATA_W-1:0]           mem_q
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0]    grant_count
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   cand;
  logic               found;
  logic               grant_vld;
  logic               rd_push;
  logic [ADDR_W-1:0]  last_addr;
  logic [DATA_W-1:0]  last_data;

  // Read tag pipe: stage 0 is loaded on the grant edge, the last stage lines up with mem_q.
  logic [MEM_RD_LAT-1:0] pipe_vld;
  logic [IDX_W-1:0]      pipe_idx [MEM_RD_LAT];
  logic                  pipe_empty;

  // Rotating priority search starting at rr_ptr; first requesting index wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Gating with rst keeps the grant quiet while reset is held, so no write can slip out.
  assign grant_vld = found && (state == S_RUN) && !rst;
  assign rd_push   = grant_vld && !we[win];
  assign gnt       = grant_vld ? (NUM_REQ'(1) << win) : '0;

  // Address/data follow the winner; with no grant they hold the last driven value.
  assign mem_wren    = grant_vld && we[win];
  assign mem_address = grant_vld ? addr[int'(win)*ADDR_W +: ADDR_W]  : last_addr;
  assign mem_data    = grant_vld ? wdata[int'(win)*DATA_W +: DATA_W] : last_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      last_addr <= '0;
      last_data <= '0;
    end else if (grant_vld) begin
      rr_ptr    <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
      last_addr <= mem_address;
      last_data <= mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int s = 0; s < MEM_RD_LAT; s++) begin
        pipe_idx[s] <= '0;
      end
    end else begin
      pipe_vld[0] <= rd_push;
      pipe_idx[0] <= win;
      for (int s = 1; s < MEM_RD_LAT; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_idx[s] <= pipe_idx[s-1];
      end
    end
  end

  assign pipe_empty = ~|pipe_vld;
  assign rvalid     = pipe_vld[MEM_RD_LAT-1] ? (NUM_REQ'(1) << pipe_idx[MEM_RD_LAT-1]) : '0;
  assign rdata      = pipe_vld[MEM_RD_LAT-1] ? mem_q : '0;

  // Pause/drain FSM. A grant issued in the cycle pause is sampled still completes normally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: begin
        if (pause) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // Releasing pause mid-drain resumes at once; outstanding reads still return.
        if (!pause)          state_nxt = S_RUN;
        else if (pipe_empty) state_nxt = S_PAUSED;
      end
      S_PAUSED: begin
        if (!pause) state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  assign paused = (state == S_PAUSED);

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] cnt [NUM_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_vld && (win == IDX_W'(i)) && (cnt[i] != {CNT_W{1'b1}})) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
    assign grant_count[g*CNT_W +: CNT_W] = cnt[g];
  end
`endif

endmodule

// File: tb/tb_main_memory_arbiter.sv
module tb_main_memory_arbiter;
  localparam int NR = 4;
  localparam int AW = 18;
  localparam int DW = 24;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              pause;
  logic              paused;
  logic [NR-1:0]     req;
  logic [NR-1:0]     we;
  logic [NR*AW-1:0]  addr;
  logic [NR*DW-1:0]  wdata;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     rvalid;
  logic [DW-1:0]     rdata;
  logic [AW-1:0]     mem_address;
  logic [DW-1:0]     mem_data;
  logic              mem_wren;
  logic [DW-1:0]     mem_q;
`ifdef ARB_STATS_EN
  logic [NR*CW-1:0]  grant_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  main_memory_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MEM_RD_LAT(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .pause(pause), .paused(paused),
    .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
`ifdef ARB_STATS_EN
    , .grant_count(grant_count)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle registered read, write-first, initialised to all ones.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '1;
  end
  always @(posedge clk) begin
    if (mem_wren) mem[mem_address] = mem_data;
    mem_q <= mem[mem_address];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[i] = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; pause = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    tick();
    req = '1;
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_checks++; if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0000", rvalid); end
    n_checks++; if (rdata !== 24'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 000000", rdata); end
    n_checks++; if (mem_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b want 0", mem_wren); end
    n_checks++; if (mem_address !== 18'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", mem_address); end
    n_checks++; if (mem_data !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", mem_data); end
    n_checks++; if (paused !== 1'b0) begin n_fail++; $display("FAIL reset_paused: got %b want 0", paused); end
    req = '0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    set_req(0, 1'b0, 18'd0, 24'd0);
    req = 4'b0001;
    #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL t1_gnt: got %b want 0001", gnt); end
    n_checks++; if (mem_wren !== 1'b0) begin n_fail++; $display("FAIL t1_wren: got %b want 0", mem_wren); end
    n_checks++; if (mem_address !== 18'd0) begin n_fail++; $display("FAIL t1_addr: got %h want 0", mem_address); end
    tick();
    req = 4'b0000;
    #1;
    n_checks++; if (rvalid !== 4'b0001) begin n_fail++; $display("FAIL t1_rvalid: got %b want 0001", rvalid); end
    n_checks++; if (rdata !== 24'hFFFFFF) begin n_fail++; $display("FAIL t1_rdata: got %h want ffffff", rdata); end
    tick();
    #1;
    n_checks++; if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL t1_rvalid_clr: got %b want 0000", rvalid); end
  endtask

  task automatic test_write_then_read();
    set_req(0, 1'b1, 18'd10, 24'd65535);
    req = 4'b0001;
    #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL t2_wr_gnt: got %b want 0001", gnt); end
    n_checks++; if (mem_wren !== 1'b1) begin n_fail++; $display("FAIL t2_wren: got %b want 1", mem_wren); end
    n_checks++; if (mem_address !== 18'd10) begin n_fail++; $display("FAIL t2_addr: got %0d want 10", mem_address); end
    n_checks++; if (mem_data !== 24'd65535) begin n_fail++; $display("FAIL t2_data: got %0d want 65535", mem_data); end
    tick();
    set_req(1, 1'b0, 18'd10, 24'd0);
    req = 4'b0010;
    #1;
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL t2_rd_gnt: got %b want 0010", gnt); end
    n_checks++; if (mem_wren !== 1'b0) begin n_fail++; $display("FAIL t2_rd_wren: got %b want 0", mem_wren); end
    n_checks++; if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL t2_wr_norvalid: got %b want 0000", rvalid); end
    tick();
    req = 4'b0000;
    #1;
    n_checks++; if (rvalid !== 4'b0010) begin n_fail++; $display("FAIL t2_rvalid: got %b want 0010", rvalid); end
    n_checks++; if (rdata !== 24'd65535) begin n_fail++; $display("FAIL t2_rdata: got %0d want 65535", rdata); end
    tick();
    #1;
    n_checks++; if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL t2_rvalid_clr: got %b want 0000", rvalid); end
  endtask

  task automatic test_rotation();
    logic [DW-1:0] exp_d [NR];
    exp_d[0] = 24'd65535; exp_d[1] = 24'hFFFFFF; exp_d[2] = 24'hFFFFFF; exp_d[3] = 24'hFFFFFF;
    rst = 1'b1; #1; rst = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(10 + i), 24'd0);
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      n_checks++; if (gnt !== 4'(1 << (c % 4))) begin n_fail++; $display("FAIL t3_gnt[%0d]: got %b want %b", c, gnt, 4'(1 << (c % 4))); end
      n_checks++; if (mem_address !== AW'(10 + c % 4)) begin n_fail++; $display("FAIL t3_addr[%0d]: got %0d want %0d", c, mem_address, 10 + c % 4); end
      if (c > 0) begin
        n_checks++; if (rvalid !== 4'(1 << ((c - 1) % 4))) begin n_fail++; $display("FAIL t3_rvalid[%0d]: got %b want %b", c, rvalid, 4'(1 << ((c - 1) % 4))); end
        n_checks++; if (rdata !== exp_d[(c - 1) % 4]) begin n_fail++; $display("FAIL t3_rdata[%0d]: got %h want %h", c, rdata, exp_d[(c - 1) % 4]); end
      end
      tick();
    end
    req = 4'b0000;
    #1;
    n_checks++; if (rvalid !== 4'b1000) begin n_fail++; $display("FAIL t3_last_rvalid: got %b want 1000", rvalid); end
    n_checks++; if (rdata !== 24'hFFFFFF) begin n_fail++; $display("FAIL t3_last_rdata: got %h want ffffff", rdata); end
    tick();
  endtask

  task automatic test_wrap();
    set_req(2, 1'b0, 18'd30, 24'd0);
    req = 4'b0100;
    #1;
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL t4_gnt2: got %b want 0100", gnt); end
    tick();
    set_req(0, 1'b0, 18'd31, 24'd0);
    req = 4'b0101;
    #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL t4_wrap_gnt0: got %b want 0001", gnt); end
    tick();
    #1;
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL t4_then_gnt2: got %b want 0100", gnt); end
    tick();
    req = 4'b0000;
    set_req(2, 1'b0, 18'd99, 24'd0);
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL t4_idle_gnt: got %b want 0000", gnt); end
    n_checks++; if (mem_wren !== 1'b0) begin n_fail++; $display("FAIL t4_idle_wren: got %b want 0", mem_wren); end
    n_checks++; if (mem_address !== 18'd30) begin n_fail++; $display("FAIL t4_hold_addr: got %0d want 30", mem_address); end
    n_checks++; if (rvalid !== 4'b0100) begin n_fail++; $display("FAIL t4_rvalid: got %b want 0100", rvalid); end
    tick();
  endtask

  task automatic test_pause_drain();
    int cnt;
    set_req(0, 1'b1, 18'd200000, 24'd3444);
    req = 4'b0001;
    #1;
    n_checks++; if (mem_wren !== 1'b1) begin n_fail++; $display("FAIL t5_wr_wren: got %b want 1", mem_wren); end
    tick();
    set_req(0, 1'b0, 18'd200000, 24'd0);
    pause = 1'b1;
    #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL t5_last_gnt: got %b want 0001", gnt); end
    tick();
    set_req(1, 1'b0, 18'd40, 24'd0);
    req = 4'b0010;
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL t5_drain_gnt: got %b want 0000", gnt); end
    n_checks++; if (rvalid !== 4'b0001) begin n_fail++; $display("FAIL t5_drain_rvalid: got %b want 0001", rvalid); end
    n_checks++; if (rdata !== 24'd3444) begin n_fail++; $display("FAIL t5_drain_rdata: got %0d want 3444", rdata); end
    n_checks++; if (paused !== 1'b0) begin n_fail++; $display("FAIL t5_not_yet_paused: got %b want 0", paused); end
    cnt = 0;
    while (!paused && cnt < 10) begin
      tick();
      cnt++;
    end
    #1;
    n_checks++; if (paused !== 1'b1) begin n_fail++; $display("FAIL t5_paused: got %b want 1 after %0d cycles", paused, cnt); end
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL t5_paused_gnt: got %b want 0000", gnt); end
    pause = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL t5_release_gnt: got %b want 0000", gnt); end
    tick();
    #1;
    n_checks++; if (paused !== 1'b0) begin n_fail++; $display("FAIL t5_unpaused: got %b want 0", paused); end
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL t5_resume_gnt: got %b want 0010", gnt); end
    tick();
    req = 4'b0000;
    tick();
  endtask

  task automatic test_reset_midflight();
    set_req(0, 1'b0, 18'd5, 24'd0);
    set_req(1, 1'b0, 18'd6, 24'd0);
    req = 4'b0011;
    #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL t6_gnt0: got %b want 0001", gnt); end
    tick();
    #1;
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL t6_gnt1: got %b want 0010", gnt); end
    rst = 1'b1;
    #1;
    n_checks++; if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL t6_rst_rvalid: got %b want 0000", rvalid); end
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL t6_rst_gnt: got %b want 0000", gnt); end
    tick();
    req = 4'b0000;
    rst = 1'b0;
    #1;
    n_checks++; if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL t6_rvalid_a: got %b want 0000", rvalid); end
    tick();
    #1;
    n_checks++; if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL t6_rvalid_b: got %b want 0000", rvalid); end
    req = 4'b1111;
    #1;
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL t6_ptr0_gnt: got %b want 0001", gnt); end
`ifdef ARB_STATS_EN
    n_checks++; if (grant_count !== 64'd0) begin n_fail++; $display("FAIL t6_cnt_clr: got %h want 0", grant_count); end
`endif
    set_req(3, 1'b0, 18'd10, 24'd0);
    req = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL t6_gnt3[%0d]: got %b want 1000", c, gnt); end
      tick();
    end
    req = 4'b0000;
    #1;
    n_checks++; if (rdata !== 24'd65535) begin n_fail++; $display("FAIL t6_mem_kept: got %0d want 65535", rdata); end
`ifdef ARB_STATS_EN
    n_checks++; if (grant_count !== {16'd5, 16'd0, 16'd0, 16'd0}) begin n_fail++; $display("FAIL t6_cnt5: got %h want 0005000000000000", grant_count); end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_then_read();
    test_rotation();
    test_wrap();
    test_pause_drain();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
